// File: rtl/input_controller_rpt_pkg.sv
// Shared types and board-default timing for the spaceship input front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package input_pkg;

  typedef enum logic [1:0] {
    ROT_IDLE,
    ROT_DELAY,
    ROT_REPEAT
  } rot_state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_CW,
    DIR_CCW
  } rot_dir_t;

  // Defaults for the 25 MHz board clock: 10 ms debounce, 0.5 s repeat delay,
  // 125 ms repeat period, 250 ms fire cooldown.
  localparam int DEF_ANGLE_W         = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_DELAY    = 12500000;
  localparam int DEF_REPEAT_PERIOD   = 3125000;
  localparam int DEF_FIRE_COOLDOWN   = 6250000;
  localparam int DEF_MODE_W          = 2;
  localparam int DEF_NUM_MODES       = 3;

endpackage

// File: rtl/input_controller_rpt_debouncer.sv
// Button conditioner: 2-FF synchroniser plus stable-level counter with rise pulse.
// Latency: level/rise change DEBOUNCE_CYCLES+2 cycles after a stable raw change.
// Backpressure: none; raw input is sampled every cycle.
module button_debouncer
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [1:0]    fill_q;
  logic          armed_q, armed_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sample;

  // Synchroniser chain; fill_q marks when sync2_q carries a real sample after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

  // Stable counter; a button held through reset is masked until it is seen released.
  always_comb begin
    armed_d = armed_q | (fill_q[1] & ~sync2_q);
    sample  = sync2_q & armed_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sample == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      level_d = ~level_q;
      rise_d  = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      armed_q <= armed_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/input_controller_rpt.sv
// Spaceship input front end: debounced rotation with hold-to-repeat, rate-limited fire, clamped mode.
// Latency: angle/fire 1 cycle after debounced event; fire_mode 3 cycles from raw switch.
// Backpressure: none. Optional AUTOFIRE_EN: held fire re-pulses every FIRE_COOLDOWN+1 cycles.
module input_controller_rpt
  import input_pkg::*;
#(
  parameter int ANGLE_W         = DEF_ANGLE_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int FIRE_COOLDOWN   = DEF_FIRE_COOLDOWN,
  parameter int MODE_W          = DEF_MODE_W,
  parameter int NUM_MODES       = DEF_NUM_MODES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rotate_cw_button,
  input  logic               rotate_ccw_button,
  input  logic               fire_button,
  input  logic [MODE_W-1:0]  fire_mode_switch,
  output logic [ANGLE_W-1:0] angle_state,
  output logic               fire,
  output logic [MODE_W-1:0]  fire_mode
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam int FW      = $clog2(FIRE_COOLDOWN + 1);

  logic cw_lvl, cw_rise, ccw_lvl, ccw_rise, fire_lvl, fire_rise;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cw (
    .clk(clk), .rst(rst), .raw_in(rotate_cw_button), .level(cw_lvl), .rise(cw_rise)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ccw (
    .clk(clk), .rst(rst), .raw_in(rotate_ccw_button), .level(ccw_lvl), .rise(ccw_rise)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fire (
    .clk(clk), .rst(rst), .raw_in(fire_button), .level(fire_lvl), .rise(fire_rise)
  );

  // Rotation runs on levels, so its rise pulses are intentionally left unconsumed.
  logic unused_sig;
`ifdef AUTOFIRE_EN
  assign unused_sig = cw_rise | ccw_rise;
`else
  assign unused_sig = cw_rise | ccw_rise | fire_lvl;
`endif

  // ---------------- rotation ----------------
  rot_state_t        rot_q, rot_d;
  rot_dir_t          dir, dir_q, dir_d, step_dir;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;

  // Direction is only defined when exactly one rotate button is down.
  always_comb begin
    dir = DIR_NONE;
    if (cw_lvl && !ccw_lvl)      dir = DIR_CW;
    else if (ccw_lvl && !cw_lvl) dir = DIR_CCW;
  end

  // Rotation FSM next-state: step on entry, after the delay, then every period.
  always_comb begin
    rot_d    = rot_q;
    dir_d    = dir_q;
    rcnt_d   = rcnt_q;
    step_dir = DIR_NONE;
    case (rot_q)
      ROT_IDLE: begin
        if (dir != DIR_NONE) begin
          step_dir = dir;
          dir_d    = dir;
          rcnt_d   = RW'(REPEAT_DELAY);
          rot_d    = ROT_DELAY;
        end
      end
      ROT_DELAY, ROT_REPEAT: begin
        if (dir != dir_q) begin
          rcnt_d = '0;
          rot_d  = ROT_IDLE;
        end else if (rcnt_q <= RW'(1)) begin
          step_dir = dir_q;
          rcnt_d   = RW'(REPEAT_PERIOD);
          rot_d    = ROT_REPEAT;
        end else begin
          rcnt_d = rcnt_q - RW'(1);
        end
      end
      default: rot_d = ROT_IDLE;
    endcase
  end

  // Angle step with natural modulo wrap.
  always_comb begin
    angle_d = angle_q;
    case (step_dir)
      DIR_CW:  angle_d = angle_q + ANGLE_W'(1);
      DIR_CCW: angle_d = angle_q - ANGLE_W'(1);
      default: angle_d = angle_q;
    endcase
  end

  // Rotation state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rot_q   <= ROT_IDLE;
      dir_q   <= DIR_NONE;
      rcnt_q  <= '0;
      angle_q <= '0;
    end else begin
      rot_q   <= rot_d;
      dir_q   <= dir_d;
      rcnt_q  <= rcnt_d;
      angle_q <= angle_d;
    end
  end

  // ---------------- fire ----------------
  logic          fire_q, fire_d, fire_trig;
  logic [FW-1:0] fcd_q, fcd_d;

  // Cooldown counts down on its own; a trigger is honoured only once it is idle.
  always_comb begin
`ifdef AUTOFIRE_EN
    fire_trig = fire_lvl;
`else
    fire_trig = fire_rise;
`endif
    fire_d = 1'b0;
    fcd_d  = fcd_q;
    if (fcd_q != '0) fcd_d = fcd_q - FW'(1);
    if (fire_trig && (fcd_q == '0)) begin
      fire_d = 1'b1;
      fcd_d  = FW'(FIRE_COOLDOWN);
    end
  end

  // Fire pulse and cooldown registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fire_q <= 1'b0;
      fcd_q  <= '0;
    end else begin
      fire_q <= fire_d;
      fcd_q  <= fcd_d;
    end
  end

  // ---------------- fire mode ----------------
  logic [MODE_W-1:0] msync1_q, msync2_q, mode_q, mode_d;

  // Out-of-range switch codes collapse onto the highest legal mode.
  always_comb begin
    mode_d = (int'(msync2_q) < NUM_MODES) ? msync2_q : MODE_W'(NUM_MODES - 1);
  end

  // Switch synchroniser and registered clamped mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      msync1_q <= '0;
      msync2_q <= '0;
      mode_q   <= '0;
    end else begin
      msync1_q <= fire_mode_switch;
      msync2_q <= msync1_q;
      mode_q   <= mode_d;
    end
  end

  assign angle_state = angle_q;
  assign fire        = fire_q;
  assign fire_mode   = mode_q;

endmodule

// File: doc/input_controller_rpt.md
Name: input_controller_rpt

Overview:
- Parametrised successor to the spaceship input front end.
- Synchronises and debounces the rotate-CW, rotate-CCW and fire buttons.
- Steps a wrap-around angle state, with hold-to-repeat rotation.
- Emits rate-limited single-cycle fire pulses and a clamped fire-mode code.
- Sits between the board buttons/switches and the game-logic / spaceship renderer.

Parameters:
ANGLE_W, 4, width of angle_state; angle wraps modulo 2^ANGLE_W
DEBOUNCE_CYCLES, 250000, consecutive stable synced cycles needed to accept a button level change
REPEAT_DELAY, 12500000, held cycles after the first rotation step before auto-repeat starts
REPEAT_PERIOD, 3125000, cycles between auto-repeat steps
FIRE_COOLDOWN, 6250000, minimum cycles between two fire pulses
MODE_W, 2, width of fire_mode_switch and fire_mode
NUM_MODES, 3, number of legal fire modes; switch values >= NUM_MODES clamp to NUM_MODES-1

Ports:
clk  in  1  system clock; only clock domain
rst  in  1  synchronous active-high reset
rotate_cw_button  in  1  raw asynchronous button, active-high
rotate_ccw_button  in  1  raw asynchronous button, active-high
fire_button  in  1  raw asynchronous button, active-high
fire_mode_switch  in  MODE_W  raw asynchronous switch bank
angle_state  out  ANGLE_W  current spaceship angle index
fire  out  1  single-cycle fire pulse
fire_mode  out  MODE_W  registered, clamped fire mode

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: angle_state=0, fire=0, fire_mode=0.
- Reset clears all synchronisers, debounced levels, counters and FSMs; rst mid-hold discards the hold.
- After rst, a button that is still held must release and re-press before it acts.
- Synchronisers: each raw input passes through a 2-FF synchroniser.
- Debounce, per button:
  - Counter resets whenever synced level equals the debounced level.
  - Otherwise it counts; at DEBOUNCE_CYCLES it flips the debounced level and clears.
  - Glitch shorter than DEBOUNCE_CYCLES: no effect.
- Rotation FSM, states IDLE, DELAY, REPEAT:
  - dir = CW if only debounced CW is high; CCW if only CCW is high; NONE otherwise (both or neither).
  - IDLE: on dir != NONE, step once, load counter with REPEAT_DELAY, go to DELAY.
  - DELAY: counter expiry steps once, reloads REPEAT_PERIOD, goes to REPEAT.
  - REPEAT: each expiry steps once and reloads REPEAT_PERIOD.
  - In DELAY/REPEAT, dir becoming NONE or changing value returns to IDLE with no step that cycle.
  - A new direction is accepted from IDLE on the next cycle.
  - Step: CW adds 1, CCW subtracts 1, mod 2^ANGLE_W; 2^ANGLE_W-1 + 1 = 0 and 0 - 1 = 2^ANGLE_W-1.
  - angle_state updates 1 cycle after the debounced rise / counter expiry.
- Fire:
  - Debounced rising edge with cooldown idle: fire=1 for exactly one cycle, cooldown loads FIRE_COOLDOWN.
  - Edge while cooldown is nonzero: ignored, not queued.
  - Cooldown counts down to 0 independently of the button.
- Fire mode:
  - Synced switch value v: fire_mode = v if v < NUM_MODES, else NUM_MODES-1.
  - Updated every cycle; latency from raw input is 3 cycles.
  - Not debounced.
- Counter widths: $clog2(max+1); no counter overflows, all saturate at expiry.

Optional Feature:
- AUTOFIRE_EN defined:
  - While fire is held debounced-high, a new pulse is issued each time cooldown reaches 0.
  - Pulses are exactly FIRE_COOLDOWN+1 cycles apart.
  - Release stops further pulses.
- AUTOFIRE_EN undefined: one pulse per press only.

Decomposition:
- Package input_pkg:
  - rot_state_t enum (ROT_IDLE, ROT_DELAY, ROT_REPEAT).
  - rot_dir_t enum (DIR_NONE, DIR_CW, DIR_CCW).
  - Default timing constants for the 25 MHz board clock.
- Sub-module button_debouncer:
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, rst, raw_in, level, rise.
  - Contains the 2-FF synchroniser and stable counter; instantiated three times.

Test Plan:
Bench overrides: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, FIRE_COOLDOWN=10, ANGLE_W=4.
- Reset/wrap: rst, then one CCW press held 10 cycles -> angle_state 0 -> 15; then one CW press -> 0.
- Bounce: CW toggles at 1-3 cycle intervals for 30 cycles, then stays low -> angle_state unchanged, fire=0.
- Hold repeat: CW held 60 cycles after debounce -> steps at t=0, 20, 28, 36, 44, 52 -> angle_state=6; release -> no further steps.
- Simultaneous: CW and CCW held together 50 cycles -> no steps; release CCW -> exactly one CW step, then repeat after 20.
- Fire cooldown: two fire presses with debounced rises 6 cycles apart -> one pulse. With AUTOFIRE_EN, hold 40 cycles -> pulses at 0, 11, 22, 33.
- Mode clamp: switch 0, 1, 2, 3 -> fire_mode 0, 1, 2, 2, each 3 cycles after the input change; rst mid-sequence -> fire_mode=0 next cycle.
